// File: rtl/bcd_countdown_source.sv
// BCD countdown stimulus source: loads a BCD start value and presents each count down to zero
// under a valid/ready handshake, with a minimum STEP_CYCLES spacing between presented values.
module bcd_countdown_source #(
    parameter int DIGITS      = 2,
    parameter int STEP_CYCLES = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] start_val,
    input  logic                abort,
    input  logic                ready,
    output logic                valid,
    output logic [3:0]          a_out,
    output logic                c_out,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                bad_bcd
);

    localparam int CW = 4 * DIGITS;
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT, DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;

    function automatic logic bcd_ok(input logic [CW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Ripple-borrow decrement; only applied to nonzero counts, so it never wraps.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign a_out = count[3:0];
    assign c_out = (count[3:0] == 4'd0) && (|(count >> 4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            count   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bad_bcd <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (bcd_ok(start_val)) begin
                            count   <= start_val;
                            bad_bcd <= 1'b0;
                            valid   <= 1'b1;
                            busy    <= 1'b1;
                            state   <= PRESENT;
                        end else begin
                            bad_bcd <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            count <= bcd_dec(count);
                            timer <= TW'(STEP_CYCLES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Handshake edge to next valid edge is STEP_CYCLES clocks.
                    if (timer == '0) begin
                        valid <= 1'b1;
                        state <= PRESENT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_source.sv
// Directed bench for bcd_countdown_source: a 1-digit and a 2-digit instance share clock,
// reset and handshake inputs; sel picks which one is being driven and observed.
module tb_bcd_countdown_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, ready, sel;
    logic [7:0] start_val;

    logic       v1, c1, b1, d1, bad1;
    logic [3:0] a1, cnt1;
    logic       v2, c2, b2, d2, bad2;
    logic [3:0] a2;
    logic [7:0] cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_countdown_source #(.DIGITS(1), .STEP_CYCLES(10)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .start_val(start_val[3:0]),
        .abort(abort), .ready(ready), .valid(v1), .a_out(a1), .c_out(c1), .count(cnt1),
        .busy(b1), .done(d1), .bad_bcd(bad1));

    bcd_countdown_source #(.DIGITS(2), .STEP_CYCLES(10)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .start_val(start_val),
        .abort(abort), .ready(ready), .valid(v2), .a_out(a2), .c_out(c2), .count(cnt2),
        .busy(b2), .done(d2), .bad_bcd(bad2));

    wire       vld_m  = sel ? v1 : v2;
    wire [3:0] a_m    = sel ? a1 : a2;
    wire       c_m    = sel ? c1 : c2;
    wire [7:0] cnt_m  = sel ? {4'h0, cnt1} : cnt2;
    wire       busy_m = sel ? b1 : b2;
    wire       done_m = sel ? d1 : d2;
    wire       bad_m  = sel ? bad1 : bad2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Start a sequence and follow it to the done pulse with ready held high.
    task automatic run_seq(input logic [7:0] sv);
        int n, waited;
        n = bcd2int(sv);
        start = 1'b1; start_val = sv; ready = 1'b1;
        step();
        start = 1'b0;
        for (int v = n; v >= 0; v--) begin
            waited = 0;
            while (!vld_m && waited < 40) begin
                step();
                waited++;
            end
            chk("valid", vld_m, 1);
            if (v != n) chk("spacing", waited, 10);
            chk("count", cnt_m, int2bcd(v));
            chk("a_out", a_m, v % 10);
            chk("c_out", c_m, (v % 10 == 0) && (v >= 10));
            step();
        end
        chk("done_pulse", done_m, 1);
        chk("valid_at_done", vld_m, 0);
        step();
        chk("done_end", done_m, 0);
        chk("busy_end", busy_m, 0);
    endtask

    initial begin
        logic held;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0; start_val = '0;
        #12;
        chk("rst_state2", {v2, a2, c2, cnt2, b2, d2, bad2}, '0);
        chk("rst_state1", {v1, a1, c1, cnt1, b1, d1, bad1}, '0);
        rst_n = 1'b1;
        step();

        // T1: single digit 9 down to 0
        sel = 1'b1;
        run_seq(8'h09);

        // T2: two digits from 21, borrows at 20 and 10
        sel = 1'b0;
        run_seq(8'h21);

        // T4: bad BCD rejected, then a valid start clears the flag
        start = 1'b1; start_val = 8'h3A;
        step();
        start = 1'b0;
        chk("bad_set", bad_m, 1);
        chk("bad_busy", busy_m, 0);
        chk("bad_valid", vld_m, 0);
        run_seq(8'h02);
        chk("bad_clear", bad_m, 0);

        // T3: backpressure holds 05
        start = 1'b1; start_val = 8'h05; ready = 1'b0;
        step();
        start = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (!(vld_m && a_m == 4'd5 && cnt_m == 8'h05)) held = 1'b0;
            step();
        end
        chk("bp_hold", held, 1);
        ready = 1'b1;
        step();
        chk("bp_dec", cnt_m, 8'h04);
        chk("bp_valid_low", vld_m, 0);

        // T5: start ignored while busy, abort in WAIT keeps count
        start = 1'b1; start_val = 8'h99;
        step();
        start = 1'b0;
        chk("start_ignored", cnt_m, 8'h04);
        chk("still_busy", busy_m, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_out", {busy_m, vld_m, done_m}, 3'b000);
        chk("abort_count", cnt_m, 8'h04);
        step();
        chk("abort_no_done", done_m, 0);

        // T6: async reset mid-WAIT at 07, then start value 0
        start = 1'b1; start_val = 8'h08; ready = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t6_wait_cnt", cnt_m, 8'h07);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {v2, a2, c2, cnt2, b2, d2, bad2}, '0);
        #2 rst_n = 1'b1;
        step();
        run_seq(8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
